// File: rtl/pkt_ff_wr_arb.sv
// rtl/pkt_ff_wr_arb.sv - packet-level round-robin arbiter for a packet FIFO write port
//
// Shares one packet FIFO write port among NUM_SRC packet sources. A source is
// granted on its SOP request and keeps the port until its EOP or error beat.
// A packet that stalls for 2^TOUT_W-1 cycles is aborted with an error beat, and
// the FIFO rewinds its write pointer to the last SOP location.
//
// Ports:
//   clk, rst_n                    write-domain clock, synchronous active-low reset
//   src_valid/sop/eop/error       per-source beat qualifiers [NUM_SRC]
//   src_data                      per-source data, source i at [i*DATA_W +: DATA_W]
//   src_ready                     per-source beat accept [NUM_SRC]
//   ff_full                       FIFO full (write side)
//   ff_valid/sop/eop/error/data   registered FIFO write beat
//   gnt_id                        current/last granted source
//   busy                          high while a packet is being transferred
//   tout_pulse                    one-cycle pulse when the watchdog aborts a packet
module pkt_ff_wr_arb #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int TOUT_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC-1:0]           src_sop,
  input  logic [NUM_SRC-1:0]           src_eop,
  input  logic [NUM_SRC-1:0]           src_error,
  input  logic [NUM_SRC*DATA_W-1:0]    src_data,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic                         ff_full,
  output logic                         ff_valid,
  output logic                         ff_sop,
  output logic                         ff_eop,
  output logic                         ff_error,
  output logic [DATA_W-1:0]            ff_data,
  output logic [$clog2(NUM_SRC)-1:0]   gnt_id,
  output logic                         busy,
  output logic                         tout_pulse
);

  localparam int GW = $clog2(NUM_SRC);
  // Value of the stall counter on the stall cycle that completes the timeout.
  localparam logic [TOUT_W-1:0] WD_LAST = {{(TOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state;
  logic                first_beat;
  logic [TOUT_W-1:0]   wd_cnt;

  logic                g_valid, g_sop, g_eop, g_error;
  logic [DATA_W-1:0]   g_data;
  logic                accept, sop_rewind, pkt_end;
  logic                found;
  logic [GW-1:0]       win_id;

  // Beat of the granted source.
  always_comb begin
    g_valid = 1'b0;
    g_sop   = 1'b0;
    g_eop   = 1'b0;
    g_error = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_id == GW'(i)) begin
        g_valid = src_valid[i];
        g_sop   = src_sop[i];
        g_eop   = src_eop[i];
        g_error = src_error[i];
        g_data  = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign accept     = (state == XFER) & g_valid & ~ff_full;
  // A fresh SOP inside a packet means the source restarted; the partial packet
  // must be discarded, so the beat goes out as an error instead of a new SOP.
  assign sop_rewind = g_sop & ~first_beat;
  assign pkt_end    = g_eop | g_error | sop_rewind;
  assign busy       = (state == XFER);

  // In IDLE, non-SOP beats are acknowledged and dropped so a source that lost
  // packet framing can drain back to a SOP.
  always_comb begin
    src_ready = '0;
    if (rst_n) begin
      if (state == IDLE) begin
        src_ready = src_valid & ~src_sop;
      end else begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (gnt_id == GW'(i)) src_ready[i] = ~ff_full;
        end
      end
    end
  end

  // Circular search starting just after the last winner, so the last winner
  // is visited last.
  always_comb begin
    found  = 1'b0;
    win_id = gnt_id;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!found && src_valid[(int'(gnt_id) + k) % NUM_SRC]
                 && src_sop[(int'(gnt_id) + k) % NUM_SRC]) begin
        found  = 1'b1;
        win_id = GW'((int'(gnt_id) + k) % NUM_SRC);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      first_beat <= 1'b0;
      wd_cnt     <= '0;
      gnt_id     <= GW'(NUM_SRC - 1);
      ff_valid   <= 1'b0;
      ff_sop     <= 1'b0;
      ff_eop     <= 1'b0;
      ff_error   <= 1'b0;
      ff_data    <= '0;
      tout_pulse <= 1'b0;
    end else begin
      ff_valid   <= 1'b0;
      ff_sop     <= 1'b0;
      ff_eop     <= 1'b0;
      ff_error   <= 1'b0;
      ff_data    <= '0;
      tout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (found) begin
            gnt_id     <= win_id;
            first_beat <= 1'b1;
            state      <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            ff_valid   <= 1'b1;
            ff_sop     <= g_sop & first_beat;
            ff_eop     <= g_eop;
            ff_error   <= g_error | sop_rewind;
            ff_data    <= g_data;
            first_beat <= 1'b0;
            wd_cnt     <= '0;
            if (pkt_end) state <= IDLE;
          end else if (wd_cnt == WD_LAST) begin
            // Rewind needs no FIFO space, so this beat ignores ff_full.
            ff_valid   <= 1'b1;
            ff_error   <= 1'b1;
            tout_pulse <= 1'b1;
            wd_cnt     <= '0;
            state      <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_ff_wr_arb.sv
// tb/tb_pkt_ff_wr_arb.sv - self-checking bench for pkt_ff_wr_arb
module tb_pkt_ff_wr_arb;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int GW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS-1:0]     src_valid, src_sop, src_eop, src_error, src_ready;
  logic [NS*DW-1:0]  src_data;
  logic              ff_full, ff_valid, ff_sop, ff_eop, ff_error;
  logic [DW-1:0]     ff_data;
  logic [GW-1:0]     gnt_id;
  logic              busy, tout_pulse;

  always #5 clk = ~clk;

  pkt_ff_wr_arb #(.NUM_SRC(NS), .DATA_W(DW), .TOUT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
    .src_error(src_error), .src_data(src_data), .src_ready(src_ready),
    .ff_full(ff_full), .ff_valid(ff_valid), .ff_sop(ff_sop), .ff_eop(ff_eop),
    .ff_error(ff_error), .ff_data(ff_data), .gnt_id(gnt_id), .busy(busy),
    .tout_pulse(tout_pulse)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic          sop, eop, err;
  } beat_t;
  beat_t fq[$];

  typedef struct {
    logic          v, s, e;
    logic [DW-1:0] d;
    logic [NS-1:0] x_rdy;
    logic          x_val, x_sop, x_eop;
    logic [DW-1:0] x_data;
    logic          x_busy;
    logic [GW-1:0] x_gnt;
  } vec_t;
  vec_t tbl[7];

  // Reference model: packet owner, stall count, and the beat expected on the
  // FIFO port during the current cycle.
  bit            m_busy, m_first;
  int            m_gnt, m_stall;
  bit            e_valid, e_sop, e_eop, e_err, e_tout;
  logic [DW-1:0] e_data;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [NS-1:0] model_ready();
    logic [NS-1:0] r;
    r = '0;
    if (rst_n !== 1'b1) return '0;
    if (!m_busy) r = src_valid & ~src_sop;
    else         r[m_gnt] = ~ff_full;
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_first = 0; m_gnt = NS - 1; m_stall = 0;
    e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0; e_tout = 0; e_data = '0;
  endtask

  task automatic model_edge();
    int  g;
    bit  restart;
    if (rst_n !== 1'b1) begin
      model_reset();
      return;
    end
    e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0; e_tout = 0; e_data = '0;
    if (!m_busy) begin
      for (int k = 1; k <= NS; k++) begin
        int idx;
        idx = (m_gnt + k) % NS;
        if (src_valid[idx] && src_sop[idx]) begin
          m_gnt = idx; m_busy = 1; m_first = 1; m_stall = 0;
          break;
        end
      end
    end else begin
      g = m_gnt;
      if (src_valid[g] && !ff_full) begin
        restart = src_sop[g] && !m_first;
        e_valid = 1;
        e_sop   = src_sop[g] && m_first;
        e_eop   = src_eop[g];
        e_err   = src_error[g] || restart;
        e_data  = src_data[g*DW +: DW];
        m_first = 0;
        m_stall = 0;
        if (src_eop[g] || src_error[g] || restart) m_busy = 0;
      end else begin
        m_stall++;
        if (m_stall == (1 << TW) - 1) begin
          e_valid = 1; e_err = 1; e_tout = 1;
          m_busy = 0; m_stall = 0;
        end
      end
    end
  endtask

  task automatic settle();
    #1;
    chk("src_ready", src_ready, model_ready());
    chk("ff_valid", ff_valid, e_valid);
    chk("ff_sop", ff_sop, e_sop);
    chk("ff_eop", ff_eop, e_eop);
    chk("ff_error", ff_error, e_err);
    chk("ff_data", ff_data, e_data);
    chk("tout_pulse", tout_pulse, e_tout);
    chk("busy", busy, m_busy);
    chk("gnt_id", gnt_id, m_gnt);
    if (ff_valid === 1'b1) fq.push_back('{cyc, ff_data, ff_sop, ff_eop, ff_error});
  endtask

  task automatic adv();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    src_valid = '0; src_sop = '0; src_eop = '0; src_error = '0;
    src_data = '0; ff_full = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    settle();
    adv();
    rst_n = 1'b1;
    fq.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    cyc++;

    // Reset state
    settle();
    chk("rst_gnt_id", gnt_id, NS - 1);
    chk("rst_busy", busy, 0);
    chk("rst_ff_valid", ff_valid, 0);
    chk("rst_src_ready", src_ready, 0);
    adv();
    rst_n = 1'b1;

    // Single source 0, 4-beat packet
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'hA0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 2'd3};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'hA0, 4'b0001, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 2'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'hA1, 4'b0001, 1'b1, 1'b1, 1'b0, 32'hA0, 1'b1, 2'd0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'hA2, 4'b0001, 1'b1, 1'b0, 1'b0, 32'hA1, 1'b1, 2'd0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'hA3, 4'b0001, 1'b1, 1'b0, 1'b0, 32'hA2, 1'b1, 2'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h0,  4'b0000, 1'b1, 1'b0, 1'b1, 32'hA3, 1'b0, 2'd0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0,  4'b0000, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 2'd0};
    for (int r = 0; r < 7; r++) begin
      src_valid[0] = tbl[r].v;
      src_sop[0]   = tbl[r].s;
      src_eop[0]   = tbl[r].e;
      src_data[DW-1:0] = tbl[r].d;
      settle();
      chk("t1_ready", src_ready, tbl[r].x_rdy);
      chk("t1_valid", ff_valid, tbl[r].x_val);
      chk("t1_sop", ff_sop, tbl[r].x_sop);
      chk("t1_eop", ff_eop, tbl[r].x_eop);
      chk("t1_data", ff_data, tbl[r].x_data);
      chk("t1_busy", busy, tbl[r].x_busy);
      chk("t1_gnt", gnt_id, tbl[r].x_gnt);
      adv();
    end

    // All sources request continuously with 2-beat packets
    begin
      int b[NS];
      do_reset();
      for (int i = 0; i < NS; i++) b[i] = 0;
      for (int n = 0; n < 24; n++) begin
        src_valid = '1;
        for (int i = 0; i < NS; i++) begin
          src_sop[i] = (b[i] == 0);
          src_eop[i] = (b[i] == 1);
          src_data[i*DW +: DW] = 32'hB000_0000 | (i << 4) | b[i];
        end
        settle();
        for (int i = 0; i < NS; i++) if (src_ready[i]) b[i] ^= 1;
        adv();
      end
      clear_inputs();
      chk("t2_beat_count", fq.size() >= 10, 1);
      if (fq.size() >= 10) begin
        for (int p = 0; p < 5; p++) begin
          chk("t2_sop_src", fq[2*p].data, 32'hB000_0000 | ((p % NS) << 4));
          chk("t2_sop_flag", fq[2*p].sop, 1);
          chk("t2_eop_src", fq[2*p+1].data, 32'hB000_0001 | ((p % NS) << 4));
          chk("t2_eop_flag", fq[2*p+1].eop, 1);
          chk("t2_contig", fq[2*p+1].cyc - fq[2*p].cyc, 1);
          if (p > 0) chk("t2_gap", fq[2*p].cyc - fq[2*p-1].cyc, 2);
        end
      end
    end

    // Source 1 with FIFO full for 5 cycles mid-packet
    begin
      int b, full_n, blocked, tout_seen;
      do_reset();
      b = 0; full_n = 0; blocked = 0; tout_seen = 0;
      for (int n = 0; n < 30; n++) begin
        src_valid[1] = (b < 4);
        src_sop[1]   = (b == 0);
        src_eop[1]   = (b == 3);
        src_data[DW +: DW] = 32'hC0 + b;
        ff_full = (b == 2 && full_n < 5);
        if (ff_full) full_n++;
        settle();
        if (ff_full) begin
          chk("t3_ready_full", src_ready[1], 0);
          blocked++;
        end
        if (tout_pulse) tout_seen++;
        if (src_valid[1] && src_ready[1]) b++;
        adv();
      end
      clear_inputs();
      chk("t3_blocked", blocked, 5);
      chk("t3_beats", fq.size(), 4);
      for (int i = 0; i < fq.size() && i < 4; i++) chk("t3_data", fq[i].data, 32'hC0 + i);
      chk("t3_no_tout", tout_seen, 0);
    end

    // Source 2 stalls after 2 beats, watchdog aborts, source 3 is next
    begin
      int b2, last_acc, tc;
      do_reset();
      b2 = 0; last_acc = -1; tc = -1;
      for (int n = 0; n < 60; n++) begin
        src_valid = '0; src_sop = '0;
        src_valid[2] = (b2 < 2);
        src_sop[2]   = (b2 == 0);
        src_data[2*DW +: DW] = 32'hD0 + b2;
        if (b2 >= 1) begin
          src_valid[0] = 1'b1; src_sop[0] = 1'b1;
          src_valid[3] = 1'b1; src_sop[3] = 1'b1;
        end
        settle();
        if (src_valid[2] && src_ready[2]) begin
          b2++;
          last_acc = cyc;
        end
        if (tout_pulse === 1'b1 && tc < 0) begin
          tc = cyc;
          chk("t4_err_valid", ff_valid, 1);
          chk("t4_err_flag", ff_error, 1);
          chk("t4_err_sop", ff_sop, 0);
          chk("t4_err_eop", ff_eop, 0);
          chk("t4_err_data", ff_data, 0);
          chk("t4_idle", busy, 0);
        end
        if (tc >= 0 && cyc == tc + 1) begin
          chk("t4_next_gnt", gnt_id, 3);
          chk("t4_next_busy", busy, 1);
          adv();
          break;
        end
        adv();
      end
      clear_inputs();
      chk("t4_tout_seen", tc >= 0, 1);
      chk("t4_stall_len", tc - last_acc, 16);
    end

    // Second SOP inside a packet forces a rewind
    begin
      bit            vv[6] = '{1, 1, 1, 1, 0, 0};
      bit            ss[6] = '{1, 1, 0, 1, 0, 0};
      logic [DW-1:0] dd[6] = '{32'hE0, 32'hE0, 32'hE1, 32'hE2, 32'h0, 32'h0};
      do_reset();
      for (int n = 0; n < 6; n++) begin
        src_valid[0] = vv[n];
        src_sop[0]   = ss[n];
        src_data[DW-1:0] = dd[n];
        settle();
        if (n == 4) chk("t5_busy_idle", busy, 0);
        adv();
      end
      clear_inputs();
      chk("t5_beats", fq.size(), 3);
      if (fq.size() >= 3) begin
        chk("t5_first_sop", fq[0].sop, 1);
        chk("t5_first_err", fq[0].err, 0);
        chk("t5_third_sop", fq[2].sop, 0);
        chk("t5_third_err", fq[2].err, 1);
        chk("t5_third_data", fq[2].data, 32'hE2);
      end
    end

    // Stray beat flushed in IDLE, then reset in the middle of a packet
    do_reset();
    src_valid[3] = 1'b1;
    src_data[3*DW +: DW] = 32'hF0;
    settle();
    chk("t6_flush_ready", src_ready[3], 1);
    adv();
    clear_inputs();
    settle();
    chk("t6_flush_novalid", ff_valid, 0);
    adv();
    src_valid[1] = 1'b1; src_sop[1] = 1'b1; src_data[DW +: DW] = 32'hF1;
    settle(); adv();
    settle(); adv();
    src_sop[1] = 1'b0; src_data[DW +: DW] = 32'hF2;
    settle(); adv();
    rst_n = 1'b0;
    settle(); adv();
    rst_n = 1'b1;
    clear_inputs();
    settle();
    chk("t6_rst_valid", ff_valid, 0);
    chk("t6_rst_error", ff_error, 0);
    chk("t6_rst_data", ff_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_gnt", gnt_id, NS - 1);
    adv();

    // Randomized traffic against the reference model
    do_reset();
    for (int ep = 0; ep < 40; ep++) begin
      int pv, pf;
      pv = (ep % 3 == 0) ? 10 : ((ep % 3 == 1) ? 50 : 90);
      pf = (ep % 2 == 0) ? 0 : 30;
      for (int n = 0; n < 40; n++) begin
        for (int i = 0; i < NS; i++) begin
          src_valid[i] = ($urandom_range(99) < pv);
          src_sop[i]   = ($urandom_range(99) < 40);
          src_eop[i]   = ($urandom_range(99) < 30);
          src_error[i] = ($urandom_range(99) < 5);
          src_data[i*DW +: DW] = $urandom;
        end
        ff_full = ($urandom_range(99) < pf);
        settle();
        adv();
      end
    end
    clear_inputs();
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
